// File: rtl/phase_sequencer.sv
// phase_sequencer: four-arm intersection controller; MAIN/TURN/WALK phases separated by all-red CLR.
// Define TURN_GAPOUT_EN to let TURN end early after GAP_TIME consecutive idle turn_sensor samples.
module phase_sequencer #(
    parameter int TIMER_W    = 8,
    parameter int MIN_GREEN  = 16,
    parameter int TURN_TIME  = 8,
    parameter int WALK_TIME  = 10,
    parameter int CLEAR_TIME = 3,
    parameter int GAP_TIME   = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pedestrian_button,
    input  logic       turn_sensor,
    output logic       pedestrian_green,
    output logic       up_green,
    output logic       down_green,
    output logic       turn_green,
    output logic       ped_waiting,
    output logic       turn_waiting,
    output logic [1:0] phase
);
    typedef enum logic [1:0] {CLR = 2'd0, MAIN = 2'd1, TURN = 2'd2, WALK = 2'd3} state_t;

    localparam logic [TIMER_W-1:0] CLR_LD  = TIMER_W'(CLEAR_TIME - 1);
    localparam logic [TIMER_W-1:0] MAIN_LD = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] TURN_LD = TIMER_W'(TURN_TIME - 1);
    localparam logic [TIMER_W-1:0] WALK_LD = TIMER_W'(WALK_TIME - 1);

    state_t             state, state_n, nxt, nxt_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic               ped_req, turn_req, ped_n, turn_n, done, gap_out;

    assign done = timer == '0;

`ifdef TURN_GAPOUT_EN
    logic [TIMER_W-1:0] gap, gap_n;
    // Counts only while TURN persists, so leaving TURN leaves it cleared for the next entry.
    assign gap_n   = turn_sensor ? '0 : gap + 1'b1;
    assign gap_out = gap_n == TIMER_W'(GAP_TIME);
    always_ff @(posedge clock) begin
        gap <= (reset_n && state == TURN && state_n == TURN) ? gap_n : '0;
    end
`else
    // Without gap-out TURN is purely timed; GAP_TIME is kept referenced but never true here.
    assign gap_out = GAP_TIME < 0;
`endif

    always_comb begin
        state_n = state;
        nxt_n   = nxt;
        case (state)
            CLR: if (done) state_n = nxt;
            MAIN: if (done && (turn_req || ped_req)) begin
                state_n = CLR;
                nxt_n   = turn_req ? TURN : WALK;
            end
            TURN: if (done || gap_out) begin
                state_n = CLR;
                nxt_n   = ped_req ? WALK : MAIN;
            end
            default: if (done) begin
                state_n = CLR;
                nxt_n   = MAIN;
            end
        endcase
        timer_n = state_n == state ? (done ? timer : timer - 1'b1)
                : state_n == MAIN ? MAIN_LD
                : state_n == TURN ? TURN_LD
                : state_n == WALK ? WALK_LD : CLR_LD;
        // Clear only on the entry edge, where the state is not yet the served one, so a set there wins.
        ped_n  = (pedestrian_button && state != WALK) || (ped_req && !(state != WALK && state_n == WALK));
        turn_n = (turn_sensor && state != TURN) || (turn_req && !(state != TURN && state_n == TURN));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= CLR;
            nxt              <= MAIN;
            timer            <= CLR_LD;
            ped_req          <= 1'b0;
            turn_req         <= 1'b0;
            pedestrian_green <= 1'b0;
            up_green         <= 1'b0;
            down_green       <= 1'b0;
            turn_green       <= 1'b0;
        end else begin
            state            <= state_n;
            nxt              <= nxt_n;
            timer            <= timer_n;
            ped_req          <= ped_n;
            turn_req         <= turn_n;
            pedestrian_green <= state_n == WALK;
            up_green         <= state_n == MAIN || state_n == TURN;
            down_green       <= state_n == MAIN;
            turn_green       <= state_n == TURN;
        end
    end

    assign phase        = state;
    assign ped_waiting  = ped_req;
    assign turn_waiting = turn_req;
endmodule
